div_param: RTL and testbench
============================

DIV_PARAM -- requirements
Module: div_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 The block SHALL have parameter EARLY_OUT, default 1, enabling the 1-cycle fast path of REQ-016/017.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port signed_i  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-006 Port dividend_i  input  WIDTH  dividend operand.
REQ-007 Port divisor_i  input  WIDTH  divisor operand.
REQ-008 Port start_i  input  1  request a new divide.
REQ-009 Port annul_i  input  1  abort in-flight divide / block acceptance.
REQ-010 Port ready_o  output  1  high when a start can be accepted (IDLE or DONE).
REQ-011 Port valid_o  output  1  result valid, held high in DONE.
REQ-012 Port quot_o, rem_o  output  WIDTH each  quotient, remainder.
REQ-013 Port result_o  output  2*WIDTH  {rem_o, quot_o}.
REQ-014 Port div_zero_o  output  1  current result came from divisor == 0.

Function
REQ-015 States SHALL be IDLE, CALC, FIX, DONE; start accepted on an edge where ready_o=1, start_i=1, annul_i=0; operands and signed_i captured at that edge (edge E0).
REQ-016 Divisor == 0 at accept: E0 -> DONE; at E1 valid_o=1, div_zero_o=1, quot_o = all ones, rem_o = dividend_i as captured.
REQ-017 EARLY_OUT=1 and |dividend| < |divisor| (magnitudes per signed_i), divisor != 0: E0 -> DONE; at E1 valid_o=1, quot_o=0, rem_o = dividend_i as captured, div_zero_o=0.
REQ-018 Otherwise E0 -> CALC; magnitudes formed; iteration counter cleared to 0.
REQ-019 CALC SHALL perform one radix-2 restoring step per cycle on a (2*WIDTH+1)-bit shift register: trial subtract WIDTH+1 bits; if non-negative, keep difference and shift in 1, else shift in 0.
REQ-020 CALC SHALL run exactly WIDTH steps (edges E1..E_WIDTH), then enter FIX.
REQ-021 FIX (edge E_WIDTH+1): quotient negated iff signed_i and operand signs differ; remainder negated iff signed_i and dividend negative; outputs loaded, valid_o=1, state DONE.
REQ-022 Normal-path latency SHALL be WIDTH+1 cycles from accept edge to valid_o high (33 for WIDTH=32).
REQ-023 Signed most-negative / -1 SHALL yield quot_o = most-negative value, rem_o = 0, no flag.
REQ-024 DONE SHALL hold outputs and valid_o stable until the next accepted start; accept in DONE clears valid_o and div_zero_o on that edge.
REQ-025 annul_i=1 in CALC or FIX SHALL return to IDLE on that edge with valid_o=0; no result produced.
REQ-026 annul_i=1 in DONE SHALL return to IDLE, clear valid_o, div_zero_o, quot_o, rem_o.
REQ-027 start_i while ready_o=0 SHALL be ignored (no queuing); operand changes during CALC SHALL not affect the result.
REQ-028 ready_o SHALL be combinational from state only.

Reset
REQ-029 rst=1 SHALL force IDLE, valid_o=0, div_zero_o=0, quot_o=0, rem_o=0, counter 0, overriding start_i and annul_i; applies mid-CALC with no result emitted.
REQ-030 First accept possible on the first edge after rst deasserts.

Verification
REQ-031 WIDTH=32 unsigned 100/7 -> valid_o 33 cycles after accept, quot_o=14, rem_o=2.
REQ-032 WIDTH=32 signed -7/2 -> quot_o=0xFFFFFFFD (-3), rem_o=0xFFFFFFFF (-1); 7/-2 -> quot -3, rem 1.
REQ-033 Divisor 0, dividend 0x1234 -> valid_o one cycle after accept, div_zero_o=1, quot_o=0xFFFFFFFF, rem_o=0x1234.
REQ-034 EARLY_OUT=1 unsigned 5/9 -> valid one cycle later, quot 0, rem 5; EARLY_OUT=0 same -> 33 cycles, same values.
REQ-035 annul_i at CALC step 10, then rst mid-CALC of a second divide -> no valid_o pulse, IDLE, ready_o=1 next cycle.
REQ-036 WIDTH=8 signed 0x80/0xFF -> quot 0x80, rem 0 after 9 cycles; back-to-back start in DONE -> valid_o drops next edge, new result after 9 cycles.

Source files
------------

// File: rtl/div_param.sv
// Radix-2 restoring divider, signed/unsigned; WIDTH+1 cycle latency, 1 cycle for divide-by-zero and early-out.
// No queuing: start is only taken while ready_o is high, annul_i aborts work in flight or clears a held result.
module div_param #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   quot_o,
    output logic [WIDTH-1:0]   rem_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_q, neg_r;
    logic               fast_pend, fast_dz;

    logic               accept, dvd_neg, dvs_neg, dvs_zero, early, last_step;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag, q_mag, r_mag;
    logic [2*WIDTH+1:0] sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH:0]   acc_step;

    assign ready_o   = (state == IDLE) || (state == DONE);
    assign accept    = ready_o && start_i && !annul_i;
    assign dvd_neg   = signed_i && dividend_i[WIDTH-1];
    assign dvs_neg   = signed_i && divisor_i[WIDTH-1];
    assign dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_mag   = dvs_neg ? -divisor_i : divisor_i;
    assign dvs_zero  = (divisor_i == '0);
    assign early     = EARLY_OUT && (dvd_mag < dvs_mag);
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign result_o  = {rem_o, quot_o};

    // acc = {partial remainder (WIDTH+1), quotient/dividend bits (WIDTH)}
    assign sh       = {acc, 1'b0};
    assign diff     = sh[2*WIDTH+1:WIDTH] - {2'b00, dvs_q};
    assign acc_step = diff[WIDTH+1] ? sh[2*WIDTH:0]
                                    : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
    assign q_mag    = acc[WIDTH-1:0];
    assign r_mag    = acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (annul_i && state != IDLE) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = (dvs_zero || early) ? DONE : CALC;
        end else begin
            case (state)
                CALC:    if (last_step) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            div_zero_o <= 1'b0;
            quot_o     <= '0;
            rem_o      <= '0;
            cnt        <= '0;
            acc        <= '0;
            dvs_q      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            fast_pend  <= 1'b0;
            fast_dz    <= 1'b0;
        end else if (annul_i && state != IDLE) begin
            valid_o    <= 1'b0;
            div_zero_o <= 1'b0;
            quot_o     <= '0;
            rem_o      <= '0;
            fast_pend  <= 1'b0;
        end else if (accept) begin
            valid_o    <= 1'b0;
            div_zero_o <= 1'b0;
            cnt        <= '0;
            acc        <= {{(WIDTH+1){1'b0}}, dvd_mag};
            dvs_q      <= dvs_mag;
            neg_q      <= dvd_neg ^ dvs_neg;
            neg_r      <= dvd_neg;
            fast_pend  <= dvs_zero || early;
            fast_dz    <= dvs_zero;
            // Fast results are staged now and flagged valid one edge later
            if (dvs_zero || early) begin
                quot_o <= dvs_zero ? '1 : '0;
                rem_o  <= dividend_i;
            end
        end else begin
            case (state)
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    quot_o  <= neg_q ? -q_mag : q_mag;
                    rem_o   <= neg_r ? -r_mag : r_mag;
                    valid_o <= 1'b1;
                end
                DONE: begin
                    if (fast_pend) begin
                        valid_o    <= 1'b1;
                        div_zero_o <= fast_dz;
                        fast_pend  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_param.sv
// Bench for div_param: two 32-bit instances (early-out on/off) driven in lockstep plus one 8-bit instance.
module tb_div_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sgn, start, annul;
    logic [31:0] dvd, dvs;
    logic        a_rdy, a_vld, a_dz, b_rdy, b_vld, b_dz;
    logic [31:0] a_q, a_r, b_q, b_r;
    logic [63:0] a_res, b_res;

    logic        c_sgn, c_start, c_annul;
    logic [7:0]  c_dvd, c_dvs, c_q, c_r;
    logic        c_rdy, c_vld, c_dz;
    logic [15:0] c_res;

    int tests = 0;
    int fails = 0;

    div_param #(.WIDTH(32), .EARLY_OUT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .signed_i(sgn), .dividend_i(dvd), .divisor_i(dvs),
        .start_i(start), .annul_i(annul), .ready_o(a_rdy), .valid_o(a_vld),
        .quot_o(a_q), .rem_o(a_r), .result_o(a_res), .div_zero_o(a_dz));

    div_param #(.WIDTH(32), .EARLY_OUT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .signed_i(sgn), .dividend_i(dvd), .divisor_i(dvs),
        .start_i(start), .annul_i(annul), .ready_o(b_rdy), .valid_o(b_vld),
        .quot_o(b_q), .rem_o(b_r), .result_o(b_res), .div_zero_o(b_dz));

    div_param #(.WIDTH(8), .EARLY_OUT(1'b1)) dut_c (
        .clk(clk), .rst(rst), .signed_i(c_sgn), .dividend_i(c_dvd), .divisor_i(c_dvs),
        .start_i(c_start), .annul_i(c_annul), .ready_o(c_rdy), .valid_o(c_vld),
        .quot_o(c_q), .rem_o(c_r), .result_o(c_res), .div_zero_o(c_dz));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on w-bit operands; latency from the accept rules
    task automatic model(input int w, input bit s, input logic [63:0] n, input logic [63:0] d,
                         input bit eo, output logic [63:0] q, output logic [63:0] r,
                         output bit dz, output int lat);
        logic [63:0] mask;
        longint sn, sd, an, ad;
        mask = (64'd1 << w) - 64'd1;
        dz = (d == 64'd0);
        if (dz) begin
            q = mask; r = n; lat = 1;
        end else if (s) begin
            sn = n[w-1] ? $signed(n | ~mask) : $signed(n);
            sd = d[w-1] ? $signed(d | ~mask) : $signed(d);
            q = 64'(sn / sd) & mask;
            r = 64'(sn % sd) & mask;
            an = (sn < 0) ? -sn : sn;
            ad = (sd < 0) ? -sd : sd;
            lat = (eo && an < ad) ? 1 : w + 1;
        end else begin
            q = n / d; r = n % d;
            lat = (eo && n < d) ? 1 : w + 1;
        end
    endtask

    task automatic go32(input bit s, input logic [31:0] n, input logic [31:0] d, input bit now);
        logic [63:0] eq, er;
        bit edz;
        int ela, elb, la, lb;
        if (!now) @(negedge clk);
        sgn = s; dvd = n; dvs = d; start = 1'b1; annul = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; sgn = 1'($urandom); dvd = $urandom; dvs = $urandom;
        chk("acc_clr_a", 64'(a_vld), 64'd0);
        chk("acc_clr_b", 64'(b_vld), 64'd0);
        model(32, s, 64'(n), 64'(d), 1'b1, eq, er, edz, ela);
        model(32, s, 64'(n), 64'(d), 1'b0, eq, er, edz, elb);
        la = 0; lb = 0;
        for (int c = 1; c <= 60 && (la == 0 || lb == 0); c++) begin
            @(posedge clk); #1;
            if (a_vld && la == 0) la = c;
            if (b_vld && lb == 0) lb = c;
        end
        chk("lat_a", 64'(la), 64'(ela));
        chk("lat_b", 64'(lb), 64'(elb));
        chk("hold_a", 64'(a_vld), 64'd1);
        chk("quot_a", 64'(a_q), eq);
        chk("rem_a", 64'(a_r), er);
        chk("dz_a", 64'(a_dz), 64'(edz));
        chk("res_a", a_res, {er[31:0], eq[31:0]});
        chk("quot_b", 64'(b_q), eq);
        chk("rem_b", 64'(b_r), er);
        chk("dz_b", 64'(b_dz), 64'(edz));
    endtask

    task automatic go8(input bit s, input logic [7:0] n, input logic [7:0] d);
        logic [63:0] eq, er;
        bit edz;
        int el, l;
        @(negedge clk);
        c_sgn = s; c_dvd = n; c_dvs = d; c_start = 1'b1; c_annul = 1'b0;
        @(posedge clk); #1;
        c_start = 1'b0; c_sgn = 1'($urandom); c_dvd = 8'($urandom); c_dvs = 8'($urandom);
        chk("acc_clr_c", 64'(c_vld), 64'd0);
        model(8, s, 64'(n), 64'(d), 1'b1, eq, er, edz, el);
        l = 0;
        for (int c = 1; c <= 30 && l == 0; c++) begin
            @(posedge clk); #1;
            if (c_vld) l = c;
            // A start while busy must be dropped
            c_start = (c == 3 && el > 5 && l == 0);
        end
        c_start = 1'b0;
        chk("lat_c", 64'(l), 64'(el));
        chk("quot_c", 64'(c_q), eq);
        chk("rem_c", 64'(c_r), er);
        chk("dz_c", 64'(c_dz), 64'(edz));
        chk("res_c", 64'(c_res), {48'd0, er[7:0], eq[7:0]});
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (a_vld || b_vld) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] n, d;
        rst = 1'b1; start = 1'b1; annul = 1'b1; sgn = 1'b0; dvd = 32'd100; dvs = 32'd7;
        c_start = 1'b1; c_annul = 1'b0; c_sgn = 1'b0; c_dvd = 8'd9; c_dvs = 8'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld_a", 64'(a_vld), 64'd0);
        chk("rst_dz_a", 64'(a_dz), 64'd0);
        chk("rst_res_a", a_res, 64'd0);
        chk("rst_rdy_a", 64'(a_rdy), 64'd1);
        chk("rst_vld_b", 64'(b_vld), 64'd0);
        chk("rst_vld_c", 64'(c_vld), 64'd0);
        chk("rst_res_c", 64'(c_res), 64'd0);

        @(negedge clk);
        rst = 1'b0; c_start = 1'b0;
        go32(1'b0, 32'd100, 32'd7, 1'b1);
        go32(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        go32(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        go32(1'b0, 32'h1234, 32'd0, 1'b0);
        go32(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
        go32(1'b0, 32'd5, 32'd9, 1'b0);
        go32(1'b1, 32'hFFFF_FFFB, 32'd9, 1'b0);
        go32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        go32(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        go32(1'b0, 32'd0, 32'd5, 1'b0);

        // Annul while a result is held
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1; annul = 1'b0;
        chk("anx_done_vld", 64'(a_vld), 64'd0);
        chk("anx_done_res", a_res, 64'd0);
        chk("anx_done_dz", 64'(a_dz), 64'd0);
        chk("anx_done_rdy", 64'(a_rdy), 64'd1);

        // Annul at CALC step 10, then reset during a second divide
        @(negedge clk); sgn = 1'b0; dvd = 32'd100; dvs = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1; annul = 1'b1;
        @(posedge clk); #1; annul = 1'b0;
        chk("anx_calc_vld", 64'(a_vld | b_vld), 64'd0);
        chk("anx_calc_rdy", 64'({a_rdy, b_rdy}), 64'd3);
        watch_quiet("anx_calc_quiet", 40);
        @(negedge clk); dvd = 32'd1000; dvs = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("rst_calc_vld", 64'(a_vld | b_vld), 64'd0);
        chk("rst_calc_rdy", 64'({a_rdy, b_rdy}), 64'd3);
        watch_quiet("rst_calc_quiet", 40);

        for (int i = 0; i < 20; i++) begin
            n = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'($urandom_range(1, 15));
                2:       d = -32'($urandom_range(1, 15));
                default: d = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
            endcase
            go32(1'($urandom), n, d, 1'b0);
        end

        go8(1'b1, 8'h80, 8'hFF);
        go8(1'b0, 8'd200, 8'd13);
        for (int i = 0; i < 30; i++) begin
            go8(1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
